addr_router: RTL

Parametrised, registered address router between the core's load/store port and up to N_SLAVES memory-mapped targets (data RAM, LEDs, HEX, PS/2, switches, ...). It decodes each request against per-slave base/mask windows, forwards it over a request/acknowledge handshake, waits for the selected slave, and returns one response beat with read data or an error. It generalises the old combinational decoder: slave count and address windows are configurable, slaves may stall, unmapped accesses and hung slaves produce an error response, and the first failing address is captured.

---
 rtl/addr_router.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/addr_router.sv
// Registered request/ack router from the core load/store port to N_SLAVES memory-mapped targets.
// Define ADDR_ROUTER_TIMEOUT_EN to build the wait-state timeout counter and its error path.
module addr_router #(
  parameter int unsigned                N_SLAVES       = 5,
  parameter logic [N_SLAVES*32-1:0]     SLAVE_BASE     = {32'h80003000, 32'h80002000, 32'h80001000,
                                                          32'h80000000, 32'h00000000},
  parameter logic [N_SLAVES*32-1:0]     SLAVE_MASK     = {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFF0,
                                                          32'hFFFFFFFC, 32'hFFFFFF00},
  parameter int unsigned                TIMEOUT_CYCLES = 16,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   ready_o,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic [N_SLAVES-1:0]    s_req_o,
  output logic                   s_we_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_wdata_o,
  input  logic [N_SLAVES-1:0]    s_ack_i,
  input  logic [N_SLAVES*32-1:0] s_rdata_i,
  output logic [31:0]            err_addr_o,
  output logic                   err_flag_o,
  input  logic                   err_clr_i
);

  // state | meaning
  // IDLE  | ready for a request; decode and register it on acceptance
  // WAIT  | request held on the selected slave until ack (or timeout)
  // RESP  | one-cycle response strobe back to the master
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("addr_router: parameter out of range");
  end

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic [N_SLAVES-1:0] hit_oh;
  logic                sel_ack;
  logic [31:0]         sel_rdata;
  logic                timeout;
  logic                err_evt;
  logic [31:0]         err_evt_addr;

  // Scan high to low so the lowest matching index is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit       = 1'b1;
        hit_idx   = SEL_W'(i);
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ack   = s_ack_i[i];
        sel_rdata = s_rdata_i[32*i +: 32];
      end
    end
  end

`ifdef ADDR_ROUTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  // Counter reads 0 in the first WAIT cycle, so the last counted cycle is TIMEOUT_CYCLES-1.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tmo_cnt <= '0;
    end else if (state != WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign timeout = (state == WAIT) && (tmo_cnt == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign err_evt      = ((state == IDLE) && req_i && !hit) ||
                        ((state == WAIT) && !sel_ack && timeout);
  assign err_evt_addr = (state == IDLE) ? addr_i : s_addr_o;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      s_req_o   <= '0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      sel       <= '0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            s_we_o    <= we_i;
            s_addr_o  <= addr_i;
            s_wdata_o <= wdata_i;
            ready_o   <= 1'b0;
            if (hit) begin
              sel     <= hit_idx;
              s_req_o <= hit_oh;
              state   <= WAIT;
            end else begin
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= ERR_RDATA;
              state    <= RESP;
            end
          end
        end
        WAIT: begin
          if (sel_ack) begin
            s_req_o  <= '0;
            rvalid_o <= 1'b1;
            err_o    <= 1'b0;
            rdata_o  <= s_we_o ? 32'h0 : sel_rdata;
            state    <= RESP;
          end else if (timeout) begin
            s_req_o  <= '0;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= ERR_RDATA;
            state    <= RESP;
          end
        end
        RESP: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          s_req_o <= '0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // A new error in the same cycle as a clear wins and reloads the address.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_addr_o <= '0;
      err_flag_o <= 1'b0;
    end else if (err_evt) begin
      if (!err_flag_o || err_clr_i) begin
        err_addr_o <= err_evt_addr;
        err_flag_o <= 1'b1;
      end
    end else if (err_clr_i) begin
      err_addr_o <= '0;
      err_flag_o <= 1'b0;
    end
  end

endmodule
